// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: the 32-bit word type, memory bus
// command/result structs, arbiter state encoding and byte-mask legality.
package Common;
  typedef logic [31:0] uint32;
endpackage

package MemoryBus;
  import Common::*;

  localparam int NREQ_MAX = 2;

  typedef struct packed {
    uint32      address;
    uint32      write_data;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mask_byte;
  } Cmd;

  typedef struct packed {
    uint32 read_data;
  } Result;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } ArbState;

  // Bytes, aligned halfwords and the full word are the only legal lane sets.
  function automatic logic mask_ok(input logic [3:0] mask_byte);
    case (mask_byte)
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic cmd_ok(input Cmd cmd);
    return mask_ok(cmd.mask_byte) && !(cmd.mem_read && cmd.mem_write);
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a conflict the requester that did not win
// last time gets the grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);
  always_comb begin
    any_valid = |valid;
    if (&valid) grant = ~last_grant;
    else        grant = valid[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto the single data-memory port, issuing one
// access at a time and holding a registered response until it is consumed.
module mem_arbiter
  import Common::*;
  import MemoryBus::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  Cmd              req_cmd [NREQ],
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] resp_valid,
  input  logic [NREQ-1:0] resp_ready,
  output uint32           resp_data,
  output logic            resp_err,
  output Cmd              mem_cmd,
  input  Result           mem_res
);
  ArbState         state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_grant_q, last_grant_d;
  logic            err_q, err_d;
  Cmd              mem_cmd_q, mem_cmd_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  uint32           resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            win;
  logic            any_valid;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (win),
    .any_valid  (any_valid)
  );

  // mem_cmd is loaded at accept time so the port is driven exactly during
  // ISSUE; an illegal command simply leaves it idle.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    mem_cmd_d    = mem_cmd_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[win] = 1'b1;
          gnt_d          = win;
          last_grant_d   = win;
          err_d          = !cmd_ok(req_cmd[win]);
          mem_cmd_d      = cmd_ok(req_cmd[win]) ? req_cmd[win] : '0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        resp_data_d         = mem_cmd_q.mem_read ? mem_res.read_data : '0;
        resp_err_d          = err_q;
        resp_valid_d        = '0;
        resp_valid_d[gnt_q] = 1'b1;
        mem_cmd_d           = '0;
        state_d             = RESP;
      end
      RESP: begin
        if (resp_ready[gnt_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      mem_cmd_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      mem_cmd_q    <= mem_cmd_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_cmd    = mem_cmd_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a small byte-lane memory on the port, directed
// timing scenarios and a randomized run against a transaction-level model.
module tb_mem_arbiter;
  import Common::*;
  import MemoryBus::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  Cmd          req_cmd [2];
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  uint32       resp_data;
  logic        resp_err;
  Cmd          mem_cmd;
  Result       mem_res;

  uint32       mem [16];
  uint32       ref_mem [16];
  int          write_cycles = 0;
  int          read_cycles = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_cmd    (mem_cmd),
    .mem_res    (mem_res)
  );

  function automatic uint32 merge_bytes(uint32 old, uint32 wd, logic [3:0] m);
    uint32 r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic Cmd make_cmd(uint32 addr, uint32 wd, logic rd, logic wr, logic [3:0] m);
    Cmd c;
    c.address    = addr;
    c.write_data = wd;
    c.mem_read   = rd;
    c.mem_write  = wr;
    c.mask_byte  = m;
    return c;
  endfunction

  // Memory device: combinational read, byte-lane write on the clock edge.
  always_comb mem_res.read_data = mem[mem_cmd.address[5:2]];

  always @(posedge clk) begin
    if (mem_cmd.mem_write) begin
      mem[mem_cmd.address[5:2]] <= merge_bytes(mem[mem_cmd.address[5:2]],
                                               mem_cmd.write_data, mem_cmd.mask_byte);
      write_cycles <= write_cycles + 1;
    end
    if (mem_cmd.mem_read) read_cycles <= read_cycles + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_cmd[0] = '0;
    req_cmd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction on requester r; ok drops if any bounded wait expires.
  task automatic apply_stimulus(input int r, input Cmd c, input int hold,
                                output uint32 d, output logic e, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_cmd[r]   = c;
    #1;
    n = 0;
    while (!req_ready[r] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready[r]) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[r] = 1'b0;
    n = 0;
    while (!resp_valid[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid[r]) ok = 1'b0;
    repeat (hold) @(negedge clk);
    resp_ready[r] = 1'b1;
    d = resp_data;
    e = resp_err;
    @(posedge clk);
    @(negedge clk);
    resp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_cmd[0] = '0;
    req_cmd[1] = '0;
    #1;
    compared++;
    if ({req_ready, resp_valid, resp_err} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got ready=%b valid=%b err=%b, want 0", req_ready, resp_valid, resp_err);
    end
    compared++;
    if (resp_data !== 32'h0 || mem_cmd !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got data=%h mem_cmd=%h, want 0", resp_data, mem_cmd);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got ready=%b valid=%b, want 00/00", req_ready, resp_valid);
    end
  endtask

  task automatic test_single_read();
    uint32 d; logic e; bit ok;
    apply_stimulus(1, make_cmd(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF), 0, d, e, ok);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_cmd[0]   = make_cmd(32'h10, 32'h0, 1'b1, 1'b0, 4'hF);
    #1;
    compared++;
    if (req_ready !== 2'b01 || mem_cmd.mem_read !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_cycleN: got ready=%b mem_read=%b, want 01/0", req_ready, mem_cmd.mem_read);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    compared++;
    if (mem_cmd.mem_read !== 1'b1 || mem_cmd.address !== 32'h10 || resp_valid !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL read_cycleN1: got mem_read=%b addr=%h valid=%b, want 1/10/00",
               mem_cmd.mem_read, mem_cmd.address, resp_valid);
    end
    @(negedge clk);
    compared++;
    if (mem_cmd.mem_read !== 1'b0 || resp_valid !== 2'b01 || resp_data !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_cycleN2: got mem_read=%b valid=%b data=%h err=%b, want 0/01/deadbeef/0",
               mem_cmd.mem_read, resp_valid, resp_data, resp_err);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[0] = 1'b0;
  endtask

  task automatic test_conflict();
    int grants [$];
    int gap [$];
    int last_cycle;
    int cyc;
    int expect_last;
    int expect_win;
    do_reset();
    req_cmd[0] = make_cmd(32'h10, 32'h0, 1'b1, 1'b0, 4'hF);
    req_cmd[1] = make_cmd(32'h14, 32'h0, 1'b1, 1'b0, 4'hF);
    resp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b11;
    cyc = 0;
    last_cycle = 0;
    while (grants.size() < 4 && cyc < 60) begin
      #1;
      if (req_ready != 2'b00) begin
        grants.push_back(int'(req_ready));
        gap.push_back(cyc - last_cycle);
        last_cycle = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    resp_ready = 2'b00;
    compared++;
    if (grants.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL conflict_count: got %0d grants, want 4", grants.size());
    end
    expect_last = 1;
    for (int k = 0; k < grants.size(); k++) begin
      expect_win = 1 - expect_last;
      expect_last = expect_win;
      compared++;
      if (grants[k] != (1 << expect_win)) begin
        mismatched++;
        $display("[TB] FAIL conflict_grant%0d: got ready=%0d, want %0d", k, grants[k], 1 << expect_win);
      end
      if (k > 0) begin
        compared++;
        if (gap[k] != 3) begin
          mismatched++;
          $display("[TB] FAIL conflict_spacing%0d: got %0d cycles, want 3", k, gap[k]);
        end
      end
    end
  endtask

  task automatic test_illegal_mask();
    uint32 d; logic e; bit ok;
    int wc;
    apply_stimulus(0, make_cmd(32'h20, 32'hCAFEF00D, 1'b0, 1'b1, 4'hF), 0, d, e, ok);
    wc = write_cycles;
    apply_stimulus(1, make_cmd(32'h20, 32'h12345678, 1'b0, 1'b1, 4'h6), 0, d, e, ok);
    compared++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || write_cycles != wc) begin
      mismatched++;
      $display("[TB] FAIL illegal_mask6: got ok=%0d err=%b data=%h writes=%0d, want 1/1/0/%0d",
               ok, e, d, write_cycles, wc);
    end
    apply_stimulus(1, make_cmd(32'h20, 32'h0, 1'b0, 1'b1, 4'h0), 0, d, e, ok);
    compared++;
    if (!ok || e !== 1'b1 || write_cycles != wc) begin
      mismatched++;
      $display("[TB] FAIL illegal_mask0: got ok=%0d err=%b writes=%0d, want 1/1/%0d", ok, e, write_cycles, wc);
    end
    apply_stimulus(1, make_cmd(32'h20, 32'h0, 1'b1, 1'b1, 4'hF), 0, d, e, ok);
    compared++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || write_cycles != wc) begin
      mismatched++;
      $display("[TB] FAIL illegal_rw: got ok=%0d err=%b data=%h writes=%0d, want 1/1/0/%0d",
               ok, e, d, write_cycles, wc);
    end
    apply_stimulus(0, make_cmd(32'h20, 32'h0, 1'b1, 1'b0, 4'hF), 0, d, e, ok);
    compared++;
    if (!ok || d !== 32'hCAFEF00D || e !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL illegal_readback: got ok=%0d data=%h err=%b, want 1/cafef00d/0", ok, d, e);
    end
  endtask

  task automatic test_noop();
    uint32 d; logic e; bit ok;
    int wc, rc;
    wc = write_cycles;
    rc = read_cycles;
    apply_stimulus(0, make_cmd(32'h10, 32'hFFFFFFFF, 1'b0, 1'b0, 4'hF), 0, d, e, ok);
    compared++;
    if (!ok || d !== 32'h0 || e !== 1'b0 || write_cycles != wc || read_cycles != rc) begin
      mismatched++;
      $display("[TB] FAIL noop: got ok=%0d data=%h err=%b rd=%0d wr=%0d, want 1/0/0/%0d/%0d",
               ok, d, e, read_cycles, write_cycles, rc, wc);
    end
  endtask

  task automatic test_backpressure();
    bit stable;
    int n;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_cmd[0]   = make_cmd(32'h10, 32'h0, 1'b1, 1'b0, 4'hF);
    #1;
    compared++;
    if (req_ready !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL bp_accept0: got ready=%b, want 01", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    req_cmd[1]   = make_cmd(32'h10, 32'h0, 1'b1, 1'b0, 4'hF);
    @(negedge clk);
    resp_ready = 2'b10;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp_valid !== 2'b01 || resp_data !== 32'hDEADBEEF || req_ready !== 2'b00) stable = 1'b0;
      @(negedge clk);
    end
    compared++;
    if (!stable) begin
      mismatched++;
      $display("[TB] FAIL bp_hold: got valid=%b data=%h ready=%b, want 01/deadbeef/00",
               resp_valid, resp_data, req_ready);
    end
    resp_ready = 2'b01;
    #1;
    compared++;
    if (req_ready !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL bp_no_overlap: got ready=%b, want 00", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 2'b00;
    #1;
    compared++;
    if (req_ready !== 2'b10 || resp_valid !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL bp_accept1: got ready=%b valid=%b, want 10/00", req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 0;
    while (!resp_valid[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (resp_valid !== 2'b10 || resp_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL bp_resp1: got valid=%b data=%h, want 10/deadbeef", resp_valid, resp_data);
    end
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[1] = 1'b0;
  endtask

  task automatic test_byte_write();
    uint32 d; logic e; bit ok;
    apply_stimulus(0, make_cmd(32'h30, 32'h11223344, 1'b0, 1'b1, 4'hF), 0, d, e, ok);
    apply_stimulus(1, make_cmd(32'h30, 32'h000000AB, 1'b0, 1'b1, 4'h4), 0, d, e, ok);
    compared++;
    if (!ok || e !== 1'b0 || d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL byte_write_resp: got ok=%0d err=%b data=%h, want 1/0/0", ok, e, d);
    end
    apply_stimulus(0, make_cmd(32'h30, 32'h0, 1'b1, 1'b0, 4'hF), 0, d, e, ok);
    compared++;
    if (!ok || d !== 32'h11003344) begin
      mismatched++;
      $display("[TB] FAIL byte_write_readback: got ok=%0d data=%h, want 1/11003344", ok, d);
    end
  endtask

  task automatic test_random();
    uint32 d; logic e; bit ok;
    Cmd c;
    int r, kind, wc;
    bit legal;
    uint32 exp_d;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      apply_stimulus(i % 2, make_cmd(32'(i * 4), ref_mem[i], 1'b0, 1'b1, 4'hF), 0, d, e, ok);
    end
    for (int t = 0; t < 40; t++) begin
      r    = $urandom_range(0, 1);
      kind = $urandom_range(0, 5);
      c = make_cmd(32'($urandom_range(0, 15) * 4), $urandom,
                   kind inside {0, 1, 4}, kind inside {2, 3, 4},
                   4'($urandom_range(0, 15)));
      legal = (c.mask_byte inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15})
              && !(c.mem_read && c.mem_write);
      exp_d = (legal && c.mem_read) ? ref_mem[c.address[5:2]] : 32'h0;
      wc = write_cycles;
      apply_stimulus(r, c, $urandom_range(0, 3), d, e, ok);
      if (legal && c.mem_write)
        ref_mem[c.address[5:2]] = merge_bytes(ref_mem[c.address[5:2]], c.write_data, c.mask_byte);
      compared++;
      if (!ok || d !== exp_d || e !== !legal || write_cycles != wc + int'(legal && c.mem_write)) begin
        mismatched++;
        $display("[TB] FAIL random%0d: got ok=%0d data=%h err=%b writes=%0d, want 1/%h/%b/%0d",
                 t, ok, d, e, write_cycles - wc, exp_d, !legal, int'(legal && c.mem_write));
      end
    end
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(0, make_cmd(32'(i * 4), 32'h0, 1'b1, 1'b0, 4'hF), 0, d, e, ok);
      compared++;
      if (!ok || d !== ref_mem[i]) begin
        mismatched++;
        $display("[TB] FAIL random_final%0d: got ok=%0d data=%h, want %h", i, ok, d, ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset_in_issue();
    uint32 d; logic e; bit ok;
    bit quiet;
    apply_stimulus(0, make_cmd(32'h34, 32'h0BADCAFE, 1'b0, 1'b1, 4'hF), 0, d, e, ok);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_cmd[0]   = make_cmd(32'h34, 32'hFFFFFFFF, 1'b0, 1'b1, 4'hF);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    compared++;
    if (mem_cmd.mem_write !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_issue_write: got mem_write=%b, want 1", mem_cmd.mem_write);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (mem_cmd !== '0 || resp_valid !== 2'b00 || req_ready !== 2'b00 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_issue_async: got mem_cmd=%h valid=%b ready=%b data=%h err=%b, want all 0",
               mem_cmd, resp_valid, req_ready, resp_data, resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00 || mem_cmd.mem_write !== 1'b0) quiet = 1'b0;
    end
    compared++;
    if (!quiet) begin
      mismatched++;
      $display("[TB] FAIL rst_issue_quiet: got valid=%b after reset, want 00", resp_valid);
    end
    apply_stimulus(1, make_cmd(32'h34, 32'h0, 1'b1, 1'b0, 4'hF), 0, d, e, ok);
    compared++;
    if (!ok || d !== 32'h0BADCAFE) begin
      mismatched++;
      $display("[TB] FAIL rst_issue_mem: got ok=%0d data=%h, want 1/0badcafe", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_illegal_mask();
    test_noop();
    test_backpressure();
    test_byte_write();
    test_random();
    test_reset_in_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
